// File: rtl/inpdt_mac_acc.sv
// inpdt_mac_acc: streaming 4-lane zero-point-corrected int8 dot-product accumulator.
// Accepts activation/weight beats on a valid/ready input, sums the per-beat dot
// products over a vector and presents the 32-bit result, the bias byte latched on
// the first beat and the requantizer control code on a valid/ready output.
// Optional feature macro: INPDT_SAT_EN (saturating accumulate plus sat_flag port).
module inpdt_mac_acc #(
  parameter logic [7:0]  ZERO_DATA = 8'd128,
  parameter logic [7:0]  ZERO_W    = 8'd128,
  parameter int          ACC_W     = 32,
  parameter logic [15:0] MAX_BEATS = 16'd1024,
  parameter logic [4:0]  CTRL_CODE = 5'd2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic [31:0] in_w,
  input  logic [3:0]  in_keep,
  input  logic        in_last,
  input  logic [7:0]  in_bias,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] inpdt_R_reg,
  output logic [7:0]  bias_buffer,
  output logic [4:0]  comb_ctrl,
`ifdef INPDT_SAT_EN
  output logic        len_err,
  output logic        sat_flag
`else
  output logic        len_err
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [ACC_W-1:0]   r_acc;
  logic [15:0]        r_beats;
  logic [31:0]        r_result;
  logic [7:0]         r_bias;
  logic               r_len_err;
  logic               r_out_valid;
  logic [4:0]         r_comb_ctrl;

  logic signed [17:0] w_prod [4];
  logic signed [19:0] w_beat_sum;
  logic [ACC_W-1:0]   w_base;
  logic [ACC_W-1:0]   w_acc_next;
  logic [15:0]        w_beats_inc;
  logic               w_first;

  // Per-lane zero-point correction and 9x9 signed multiply; disabled lanes give 0.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic signed [8:0] w_d;
      logic signed [8:0] w_w;
      assign w_d = $signed({1'b0, in_data[8*gi +: 8]}) - $signed({1'b0, ZERO_DATA});
      assign w_w = $signed({1'b0, in_w[8*gi +: 8]})    - $signed({1'b0, ZERO_W});
      assign w_prod[gi] = in_keep[gi] ? (w_d * w_w) : 18'sd0;
    end
  endgenerate

  // Sum of four 18-bit products cannot exceed 20 bits signed.
  assign w_beat_sum = {{2{w_prod[0][17]}}, w_prod[0]} + {{2{w_prod[1][17]}}, w_prod[1]}
                    + {{2{w_prod[2][17]}}, w_prod[2]} + {{2{w_prod[3][17]}}, w_prod[3]};

  // The first beat of a vector starts from zero instead of the stale accumulator.
  assign w_first     = (r_state == S_IDLE);
  assign w_base      = w_first ? '0 : r_acc;
  assign w_beats_inc = r_beats + 16'd1;

`ifdef INPDT_SAT_EN
  localparam int SW = 34;
  localparam logic signed [SW-1:0] L_MAX = $signed({{(SW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}});
  localparam logic signed [SW-1:0] L_MIN = $signed({{(SW-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}});
  logic signed [SW-1:0] w_sum_wide;
  logic                 w_sat_hi;
  logic                 w_sat_lo;
  logic                 r_sat;

  // Exact sum in a wide signed domain, then clamp to the accumulator range.
  assign w_sum_wide = $signed({{(SW-ACC_W){w_base[ACC_W-1]}}, w_base})
                    + $signed({{(SW-20){w_beat_sum[19]}}, w_beat_sum});
  assign w_sat_hi   = (w_sum_wide > L_MAX);
  assign w_sat_lo   = (w_sum_wide < L_MIN);
  assign w_acc_next = w_sat_hi ? L_MAX[ACC_W-1:0] :
                      w_sat_lo ? L_MIN[ACC_W-1:0] : w_sum_wide[ACC_W-1:0];

  // Saturation flag: restarts with each vector, sticky across its beats.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sat <= 1'b0;
    end else if (in_valid && in_ready) begin
      r_sat <= (w_first ? 1'b0 : r_sat) | w_sat_hi | w_sat_lo;
    end
  end

  assign sat_flag = r_sat;
`else
  // Two's-complement wrap modulo 2^ACC_W.
  assign w_acc_next = w_base + ACC_W'($signed(w_beat_sum));
`endif

  // Main FSM: gather beats, then hold the registered result until accepted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_beats     <= '0;
      r_result    <= '0;
      r_bias      <= '0;
      r_len_err   <= 1'b0;
      r_out_valid <= 1'b0;
      r_comb_ctrl <= 5'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_acc     <= w_acc_next;
            r_bias    <= in_bias;
            r_beats   <= 16'd1;
            r_len_err <= 1'b0;
            if (in_last || (MAX_BEATS == 16'd1)) begin
              r_state     <= S_DONE;
              r_len_err   <= !in_last;
              r_result    <= 32'($signed(w_acc_next));
              r_out_valid <= 1'b1;
              r_comb_ctrl <= CTRL_CODE;
            end else begin
              r_state <= S_ACC;
            end
          end
        end
        S_ACC: begin
          if (in_valid) begin
            r_acc   <= w_acc_next;
            r_beats <= w_beats_inc;
            if (in_last || (w_beats_inc == MAX_BEATS)) begin
              r_state     <= S_DONE;
              r_len_err   <= !in_last;
              r_result    <= 32'($signed(w_acc_next));
              r_out_valid <= 1'b1;
              r_comb_ctrl <= CTRL_CODE;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_comb_ctrl <= 5'd0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_comb_ctrl <= 5'd0;
        end
      endcase
    end
  end

  assign in_ready    = rstn && (r_state != S_DONE);
  assign out_valid   = r_out_valid;
  assign inpdt_R_reg = r_result;
  assign bias_buffer = r_bias;
  assign comb_ctrl   = r_comb_ctrl;
  assign len_err     = r_len_err;

endmodule

// File: tb/tb_inpdt_mac_acc.sv
// Bench for inpdt_mac_acc: directed test-plan vectors plus randomized vectors,
// checked against a plain-arithmetic reference model. Runs with ACC_W=20 and
// MAX_BEATS=9 so both wrap/saturation and forced termination are reachable.
module tb_inpdt_mac_acc;

  localparam int          ACC_W     = 20;
  localparam logic [15:0] MAX_BEATS = 16'd9;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [31:0] in_w;
  logic [3:0]  in_keep;
  logic        in_last;
  logic [7:0]  in_bias;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] inpdt_R_reg;
  logic [7:0]  bias_buffer;
  logic [4:0]  comb_ctrl;
  logic        len_err;
`ifdef INPDT_SAT_EN
  logic        sat_flag;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] q_d[$];
  logic [31:0] q_w[$];
  logic [3:0]  q_k[$];

  inpdt_mac_acc #(
    .ZERO_DATA(8'd128), .ZERO_W(8'd128), .ACC_W(ACC_W),
    .MAX_BEATS(MAX_BEATS), .CTRL_CODE(5'd2)
  ) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_w(in_w), .in_keep(in_keep),
    .in_last(in_last), .in_bias(in_bias),
    .out_valid(out_valid), .out_ready(out_ready),
    .inpdt_R_reg(inpdt_R_reg), .bias_buffer(bias_buffer),
    .comb_ctrl(comb_ctrl),
`ifdef INPDT_SAT_EN
    .len_err(len_err), .sat_flag(sat_flag)
`else
    .len_err(len_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: exact integer dot products, then either per-step clamp or final wrap.
  task automatic model(output logic [31:0] res, output bit sat);
    longint acc = 0;
    longint lim_hi = (64'sd1 <<< (ACC_W - 1)) - 1;
    longint lim_lo = -(64'sd1 <<< (ACC_W - 1));
    longint v;
    sat = 1'b0;
    for (int b = 0; b < q_d.size(); b++) begin
      logic [31:0] d = q_d[b];
      logic [31:0] w = q_w[b];
      logic [3:0]  k = q_k[b];
      for (int i = 0; i < 4; i++)
        if (k[i]) acc += (longint'(d[8*i +: 8]) - 128) * (longint'(w[8*i +: 8]) - 128);
`ifdef INPDT_SAT_EN
      if (acc > lim_hi) begin acc = lim_hi; sat = 1'b1; end
      if (acc < lim_lo) begin acc = lim_lo; sat = 1'b1; end
`endif
    end
    v = acc & ((64'sd1 <<< ACC_W) - 1);
    if (v > lim_hi) v -= (64'sd1 <<< ACC_W);
    res = v[31:0];
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [31:0] w, input logic [3:0] k,
                           input logic last, input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_w = w; in_keep = k; in_last = last; in_bias = b;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("beat_accept_timeout", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Sends the queued beats, then checks the held result and the output handshake.
  task automatic run_vec(input string tag, input bit no_last, input int hold, input logic [7:0] b);
    logic [31:0] exp_r;
    bit          exp_sat;
    int          nb = q_d.size();
    for (int i = 0; i < nb; i++)
      send_beat(q_d[i], q_w[i], q_k[i], (i == nb - 1) && !no_last, b);
    model(exp_r, exp_sat);
    chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    chk({tag, "_R"}, {32'd0, inpdt_R_reg}, {32'd0, exp_r});
    chk({tag, "_bias"}, {56'd0, bias_buffer}, {56'd0, b});
    chk({tag, "_ctrl"}, {59'd0, comb_ctrl}, 64'd2);
    chk({tag, "_lenerr"}, {63'd0, len_err}, {63'd0, no_last});
    chk({tag, "_inrdy"}, {63'd0, in_ready}, 64'd0);
`ifdef INPDT_SAT_EN
    chk({tag, "_sat"}, {63'd0, sat_flag}, {63'd0, exp_sat});
`endif
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, {63'd0, out_valid}, 64'd1);
      chk({tag, "_hold_R"}, {32'd0, inpdt_R_reg}, {32'd0, exp_r});
      chk({tag, "_hold_ctrl"}, {59'd0, comb_ctrl}, 64'd2);
      chk({tag, "_hold_inrdy"}, {63'd0, in_ready}, 64'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk({tag, "_post_valid"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_post_ctrl"}, {59'd0, comb_ctrl}, 64'd0);
    chk({tag, "_post_inrdy"}, {63'd0, in_ready}, 64'd1);
    $display("vector %s beats=%0d R=%08h bias=%02h len_err=%0b", tag, nb, exp_r, b, no_last);
  endtask

  task automatic clear_q();
    q_d.delete(); q_w.delete(); q_k.delete();
  endtask

  task automatic push(input logic [31:0] d, input logic [31:0] w, input logic [3:0] k);
    q_d.push_back(d); q_w.push_back(w); q_k.push_back(k);
  endtask

  initial begin
    rstn = 1'b0; in_valid = 1'b0; in_data = '0; in_w = '0; in_keep = '0;
    in_last = 1'b0; in_bias = '0; out_ready = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_inrdy", {63'd0, in_ready}, 64'd0);
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_R", {32'd0, inpdt_R_reg}, 64'd0);
    chk("rst_bias", {56'd0, bias_buffer}, 64'd0);
    chk("rst_ctrl", {59'd0, comb_ctrl}, 64'd0);
    chk("rst_lenerr", {63'd0, len_err}, 64'd0);
    rstn = 1'b1;
    #1 chk("idle_inrdy", {63'd0, in_ready}, 64'd1);

    // Two-beat vector, (1*2)*4 per beat.
    clear_q();
    push(32'h81818181, 32'h82828282, 4'hF);
    push(32'h81818181, 32'h82828282, 4'hF);
    run_vec("two_beat", 1'b0, 0, 8'h10);
    chk("two_beat_const", {32'd0, inpdt_R_reg}, 64'd16);

    // Negative single beat, held for 5 cycles.
    clear_q();
    push(32'h7F7F7F7F, 32'hFFFFFFFF, 4'hF);
    run_vec("neg_hold", 1'b0, 5, 8'hA5);
    chk("neg_const", {32'd0, inpdt_R_reg}, 64'hFFFFFE04);

    // Only lane 0 enabled.
    clear_q();
    push(32'hFFFFFF85, 32'h00000083, 4'b0001);
    run_vec("keep1", 1'b0, 1, 8'h3C);
    chk("keep1_const", {32'd0, inpdt_R_reg}, 64'd15);

    // All lanes disabled still counts beats and honours in_last.
    clear_q();
    push(32'h12345678, 32'h9ABCDEF0, 4'h0);
    push(32'hDEADBEEF, 32'h01020304, 4'h0);
    run_vec("keep0", 1'b0, 0, 8'h77);
    chk("keep0_const", {32'd0, inpdt_R_reg}, 64'd0);

    // Eight maximal beats overflow a 20-bit accumulator.
    clear_q();
    for (int i = 0; i < 8; i++) push(32'h0, 32'h0, 4'hF);
    run_vec("ovf", 1'b0, 0, 8'h01);
`ifdef INPDT_SAT_EN
    chk("ovf_const", {32'd0, inpdt_R_reg}, 64'h0007FFFF);
`else
    chk("ovf_const", {32'd0, inpdt_R_reg}, 64'hFFF80000);
`endif

    // MAX_BEATS reached with no in_last: forced termination and len_err.
    clear_q();
    for (int i = 0; i < int'(MAX_BEATS); i++) push($urandom, $urandom, 4'($urandom));
    run_vec("maxbeats", 1'b1, 2, 8'hC3);

    // Next vector's first beat clears len_err.
    clear_q();
    push(32'h81818181, 32'h82828282, 4'hF);
    run_vec("after_len", 1'b0, 0, 8'h5A);

    // Randomized vectors.
    for (int v = 0; v < 20; v++) begin
      int nb = $urandom_range(1, 8);
      clear_q();
      for (int i = 0; i < nb; i++) push($urandom, $urandom, 4'($urandom));
      run_vec($sformatf("rnd%0d", v), 1'b0, $urandom_range(0, 3), 8'($urandom));
    end

    // Reset in the middle of a vector discards it.
    clear_q();
    for (int i = 0; i < 3; i++) send_beat(32'h0, 32'h0, 4'hF, 1'b0, 8'hEE);
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h0; in_w = 32'h0; in_keep = 4'hF; in_last = 1'b0;
    #2 rstn = 1'b0;
    #1;
    chk("midrst_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_R", {32'd0, inpdt_R_reg}, 64'd0);
    chk("midrst_bias", {56'd0, bias_buffer}, 64'd0);
    chk("midrst_ctrl", {59'd0, comb_ctrl}, 64'd0);
    chk("midrst_lenerr", {63'd0, len_err}, 64'd0);
    chk("midrst_inrdy", {63'd0, in_ready}, 64'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst_no_out", {63'd0, out_valid}, 64'd0);
    end
    $display("vector midrst discarded");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/inpdt_mac_acc.md
Name: inpdt_mac_acc

Overview:
- Producer of the 32-bit inner-product / bias pair consumed by the LSTM bias-quantize (BQS/BQT) requantizers.
- Streams zero-point-corrected 8-bit activation/weight byte lanes, computes signed dot products and accumulates them over a vector.
- Presents the result, the latched bias byte and the matching comb_ctrl code on a valid/ready output.
- Sits between the activation/weight SRAM readers and the combinational requantize stage.

Parameters:
- ZERO_DATA, 8'd128, activation zero point subtracted from every data byte.
- ZERO_W, 8'd128, weight zero point subtracted from every weight byte.
- ACC_W, 32, accumulator width in bits, 17..32; result is sign-extended to 32 bits.
- MAX_BEATS, 16'd1024, maximum beats per vector before forced termination.
- CTRL_CODE, 5'd2, comb_ctrl value driven while out_valid is high (S_BQT).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accept.
- in_data  in  32  four activation bytes; lane k = bits [8k+7:8k].
- in_w  in  32  four weight bytes, same lane order.
- in_keep  in  4  lane enables; a disabled lane contributes 0.
- in_last  in  1  final beat of the vector.
- in_bias  in  8  bias byte; sampled on the first beat of a vector.
- out_valid  out  1  result valid.
- out_ready  in  1  result accept.
- inpdt_R_reg  out  32  signed accumulated dot product.
- bias_buffer  out  8  latched bias byte.
- comb_ctrl  out  5  CTRL_CODE while out_valid is high, else 5'd0 (comb_IDLE).
- len_err  out  1  sticky: the vector hit MAX_BEATS without in_last.

Behaviour:
- Reset: rstn low asynchronously clears state to IDLE, accumulator, beat counter, inpdt_R_reg, bias_buffer, len_err and out_valid to 0; comb_ctrl = 0; in_ready = 0 while rstn is low. Asserting reset mid-vector discards the partial sum; there is no output for that vector.
- Beat arithmetic: per lane, p_k = ($signed({1'b0,d_k}) - ZERO_DATA) * ($signed({1'b0,w_k}) - ZERO_W), 9x9 signed giving 18 bits. beat_sum = sum of the enabled p_k (20 bits signed), sign-extended to ACC_W.
- FSM:
  - IDLE: in_ready = 1. On handshake: acc <= beat_sum, bias_buffer <= in_bias, beats <= 1, len_err <= 0. If in_last, go to DONE, else go to ACC.
  - ACC: in_ready = 1. On handshake: acc <= acc + beat_sum, beats <= beats + 1. If in_last, go to DONE. If beats+1 == MAX_BEATS without in_last, go to DONE and set len_err. No handshake means hold.
  - DONE: in_ready = 0, out_valid = 1, inpdt_R_reg = sign-extended acc, comb_ctrl = CTRL_CODE. Outputs stay stable until out_ready. On out_valid & out_ready, go to IDLE; out_valid falls the next cycle.
- Latency: the last-beat handshake at cycle N gives out_valid = 1 at cycle N+1. Minimum spacing between result handshakes is 2 cycles: a one-beat vector cannot be accepted in the same cycle as the previous output handshake.
- With in_keep = 0, beat_sum = 0 but the beat still counts and in_last still applies.
- Accumulation wraps modulo 2^ACC_W unless the optional feature is enabled.
- inpdt_R_reg and bias_buffer are registered, never combinational from the inputs.

Optional Feature:
- Macro INPDT_SAT_EN.
- Defined: the accumulate step saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1] and a sat_flag output (1 bit) is added. sat_flag is cleared on the first beat and is sticky per vector.
- Undefined: two's-complement wrap and no sat_flag port.

Test Plan:
- Data 0x81818181, weights 0x82828282, keep 4'hF; two beats, the second with in_last; in_bias 0x10 -> inpdt_R_reg = 32'd16, bias_buffer = 0x10, comb_ctrl = 5'd2, out_valid one cycle after the last handshake.
- One beat with data 0x7F7F7F7F, weights 0xFFFFFFFF, in_last -> inpdt_R_reg = 0xFFFFFE04 (-508).
- keep 4'b0001, data 0xFFFFFF85, weights 0x00000083, in_last -> 15; upper lanes ignored.
- Hold out_ready = 0 for 5 cycles -> out_valid, inpdt_R_reg and comb_ctrl stable, in_ready = 0; out_ready = 1 -> out_valid = 0 next cycle, in_ready = 1.
- MAX_BEATS = 3 with in_last never asserted -> DONE after the 3rd beat, len_err = 1, sum of 3 beats presented; the next vector's first beat clears len_err.
- ACC_W = 20, data 0x00000000, weights 0x00000000, 8 beats (65536 each): without INPDT_SAT_EN -> 0xFFF80000 (-524288); with it -> 0x0007FFFF and sat_flag = 1. Drop rstn during beat 4 -> all outputs 0 immediately and no result produced.
